// File: rtl/door_input_cond.sv
// Input conditioning for the roll-door controller: sync, debounce and edge-detect keys and end sensors.
// Optional stuck-key detection is compiled in with `define KEY_STUCK_DETECT_EN.
module door_input_cond #(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 15,
    parameter int STUCK_CYCLES    = 2000000,
    parameter int STUCK_W         = 21
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_up_raw,
    input  logic key_down_raw,
    input  logic sense_up_raw,
    input  logic sense_down_raw,
    output logic key_up_pulse,
    output logic key_down_pulse,
    output logic keys_both,
    output logic sense_up,
    output logic sense_down,
    output logic sensor_fault,
    output logic key_stuck
);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } db_state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel order: 0 key_up, 1 key_down, 2 sense_up, 3 sense_down.
    logic [3:0] raw_vec;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] stable;
    logic [3:0] db_changing;

    assign raw_vec = {sense_down_raw, sense_up_raw, key_down_raw, key_up_raw};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_vec;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_db
        db_state_t        state;
        logic [CNT_W-1:0] cnt;
        logic             stable_r;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state    <= ST_STABLE;
                cnt      <= '0;
                stable_r <= 1'b0;
            end else begin
                case (state)
                    ST_STABLE: begin
                        if (sync2[i] != stable_r) begin
                            state <= ST_CHANGING;
                            cnt   <= CNT_W'(1);
                        end else begin
                            cnt <= '0;
                        end
                    end
                    ST_CHANGING: begin
                        // Any bounce back to the accepted level restarts the qualification.
                        if (sync2[i] == stable_r) begin
                            state <= ST_STABLE;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            stable_r <= sync2[i];
                            cnt      <= '0;
                            state    <= ST_STABLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_STABLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign stable[i]      = stable_r;
        assign db_changing[i] = (state == ST_CHANGING);
    end

    logic stable_up_d;
    logic stable_down_d;
    logic up_pulse_r;
    logic down_pulse_r;
    logic keys_both_r;
    logic fault_r;
    logic stuck;

    // A rise only counts as a press if the other key is not (or not newly) held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stable_up_d   <= 1'b0;
            stable_down_d <= 1'b0;
            up_pulse_r    <= 1'b0;
            down_pulse_r  <= 1'b0;
            keys_both_r   <= 1'b0;
            fault_r       <= 1'b0;
        end else begin
            stable_up_d   <= stable[0];
            stable_down_d <= stable[1];
            up_pulse_r    <= stable[0] & ~stable_up_d & ~stable[1];
            down_pulse_r  <= stable[1] & ~stable_down_d & ~stable[0];
            keys_both_r   <= stable[0] & stable[1];
            fault_r       <= fault_r | (stable[2] & stable[3]);
        end
    end

`ifdef KEY_STUCK_DETECT_EN
    localparam logic [STUCK_W-1:0] STUCK_MAX = STUCK_W'(STUCK_CYCLES);

    logic [STUCK_W-1:0] stuck_up_cnt;
    logic [STUCK_W-1:0] stuck_down_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stuck_up_cnt   <= '0;
            stuck_down_cnt <= '0;
        end else begin
            if (!stable[0])
                stuck_up_cnt <= '0;
            else if (stuck_up_cnt != STUCK_MAX)
                stuck_up_cnt <= stuck_up_cnt + STUCK_W'(1);

            if (!stable[1])
                stuck_down_cnt <= '0;
            else if (stuck_down_cnt != STUCK_MAX)
                stuck_down_cnt <= stuck_down_cnt + STUCK_W'(1);
        end
    end

    assign stuck = (stuck_up_cnt == STUCK_MAX) | (stuck_down_cnt == STUCK_MAX);
`else
    logic unused_stuck_cfg;
    assign unused_stuck_cfg = (STUCK_CYCLES > 0) && (STUCK_W > 0);
    assign stuck            = 1'b0;
`endif

    logic unused_dbg;
    assign unused_dbg = ^db_changing;

    assign key_up_pulse   = up_pulse_r & ~stuck;
    assign key_down_pulse = down_pulse_r & ~stuck;
    assign keys_both      = keys_both_r;
    assign sense_up       = stable[2];
    assign sense_down     = stable[3];
    assign sensor_fault   = fault_r;
    assign key_stuck      = stuck;

endmodule

// File: tb/tb_door_input_cond.sv
// Randomized and directed bench for door_input_cond against a run-length reference model.
module tb_door_input_cond;

    localparam int DEB   = 4;
    localparam int STUCK = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_up_raw = 1'b0, key_down_raw = 1'b0, sense_up_raw = 1'b0, sense_down_raw = 1'b0;
    logic key_up_pulse, key_down_pulse, keys_both, sense_up, sense_down, sensor_fault, key_stuck;

    door_input_cond #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(15),
        .STUCK_CYCLES(STUCK),
        .STUCK_W(21)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_up_raw(key_up_raw),
        .key_down_raw(key_down_raw),
        .sense_up_raw(sense_up_raw),
        .sense_down_raw(sense_down_raw),
        .key_up_pulse(key_up_pulse),
        .key_down_pulse(key_down_pulse),
        .keys_both(keys_both),
        .sense_up(sense_up),
        .sense_down(sense_down),
        .sensor_fault(sensor_fault),
        .key_stuck(key_stuck)
    );

    // Clock and counters
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a level is accepted once the synchronised input has
    // shown the same new value for DEB consecutive samples.
    bit [3:0] m_d1, m_d2, m_stable, m_prev, run_val;
    int       run_len [4];
    bit       m_up_p, m_dn_p, m_both, m_fault;
    int       m_stk_up, m_stk_dn;
    logic [6:0] exp_q[$];

    task automatic model_edge(input bit rst, input bit [3:0] raw);
        bit [3:0] samp;
        bit [3:0] nxt;
        bit       stk;
        if (!rst) begin
            m_d1 = '0; m_d2 = '0; m_stable = '0; m_prev = '0; run_val = '0;
            for (int c = 0; c < 4; c++) run_len[c] = 0;
            m_up_p = 0; m_dn_p = 0; m_both = 0; m_fault = 0;
            m_stk_up = 0; m_stk_dn = 0;
        end else begin
            samp = m_d2;
            m_d2 = m_d1;
            m_d1 = raw;
            nxt  = m_stable;
            for (int c = 0; c < 4; c++) begin
                if (samp[c] == run_val[c]) run_len[c]++;
                else begin
                    run_val[c] = samp[c];
                    run_len[c] = 1;
                end
                if (run_len[c] >= DEB && run_val[c] != m_stable[c]) nxt[c] = run_val[c];
            end
            m_up_p   = m_stable[0] && !m_prev[0] && !m_stable[1];
            m_dn_p   = m_stable[1] && !m_prev[1] && !m_stable[0];
            m_both   = m_stable[0] && m_stable[1];
            m_fault  = m_fault || (m_stable[2] && m_stable[3]);
            m_stk_up = m_stable[0] ? ((m_stk_up < STUCK) ? m_stk_up + 1 : STUCK) : 0;
            m_stk_dn = m_stable[1] ? ((m_stk_dn < STUCK) ? m_stk_dn + 1 : STUCK) : 0;
            m_prev   = m_stable;
            m_stable = nxt;
        end
`ifdef KEY_STUCK_DETECT_EN
        stk = (m_stk_up == STUCK) || (m_stk_dn == STUCK);
`else
        stk = 1'b0;
`endif
        exp_q.push_back({stk, m_fault, m_stable[3], m_stable[2], m_both,
                         m_dn_p && !stk, m_up_p && !stk});
    endtask

    // Driver: one clock per call, inputs applied away from the active edge
    int phase_step, up_pulses, dn_pulses, up_at, dn_at, both_at, fault_at;

    task automatic begin_phase();
        phase_step = 0; up_pulses = 0; dn_pulses = 0;
        up_at = -1; dn_at = -1; both_at = -1; fault_at = -1;
    endtask

    task automatic step(input bit rst, input bit [3:0] raw);
        logic [6:0] exp;
        @(negedge clk);
        rst_n = rst;
        {sense_down_raw, sense_up_raw, key_down_raw, key_up_raw} = raw;
        @(posedge clk);
        model_edge(rst, raw);
        #1;
        exp = exp_q.pop_front();
        check_eq("key_up_pulse", key_up_pulse, exp[0]);
        check_eq("key_down_pulse", key_down_pulse, exp[1]);
        check_eq("keys_both", keys_both, exp[2]);
        check_eq("sense_up", sense_up, exp[3]);
        check_eq("sense_down", sense_down, exp[4]);
        check_eq("sensor_fault", sensor_fault, exp[5]);
        check_eq("key_stuck", key_stuck, exp[6]);
        check_eq("pulse_exclusive", key_up_pulse & key_down_pulse, 0);
        phase_step++;
        if (key_up_pulse === 1'b1) begin up_pulses++; up_at = phase_step; end
        if (key_down_pulse === 1'b1) begin dn_pulses++; dn_at = phase_step; end
        if (keys_both === 1'b1 && both_at < 0) both_at = phase_step;
        if (sensor_fault === 1'b1 && fault_at < 0) fault_at = phase_step;
    endtask

    task automatic repeat_step(input int n, input bit rst, input bit [3:0] raw);
        for (int i = 0; i < n; i++) step(rst, raw);
    endtask

    initial begin
        bit [3:0] r;
        int       hold [4];

        // Reset state
        repeat_step(3, 1'b0, 4'b0000);
        check_eq("reset_outputs", {key_up_pulse, key_down_pulse, keys_both, sense_up,
                                   sense_down, sensor_fault, key_stuck}, 0);
        repeat_step(2, 1'b1, 4'b0000);

        // Clean press of key_up
        begin_phase();
        repeat_step(20, 1'b1, 4'b0001);
        check_eq("clean_up_count", up_pulses, 1);
        check_eq("clean_up_latency", up_at, DEB + 3);
        check_eq("clean_no_down", dn_pulses, 0);
        repeat_step(10, 1'b1, 4'b0000);

        // Bouncing key_down
        begin_phase();
        repeat_step(2, 1'b1, 4'b0010);
        repeat_step(2, 1'b1, 4'b0000);
        repeat_step(2, 1'b1, 4'b0010);
        repeat_step(2, 1'b1, 4'b0000);
        check_eq("bounce_no_pulse", dn_pulses, 0);
        begin_phase();
        repeat_step(20, 1'b1, 4'b0010);
        check_eq("bounce_down_count", dn_pulses, 1);
        check_eq("bounce_down_latency", dn_at, DEB + 3);
        repeat_step(10, 1'b1, 4'b0000);

        // Both keys together
        begin_phase();
        repeat_step(12, 1'b1, 4'b0011);
        check_eq("both_no_up", up_pulses, 0);
        check_eq("both_no_down", dn_pulses, 0);
        check_eq("both_latency", both_at, DEB + 3);
        begin_phase();
        repeat_step(12, 1'b1, 4'b0001);
        check_eq("both_release_level", keys_both, 0);
        check_eq("both_release_no_up", up_pulses, 0);
        repeat_step(10, 1'b1, 4'b0000);

        // Sensor conflict
        repeat_step(2, 1'b0, 4'b0000);
        repeat_step(10, 1'b1, 4'b0100);
        begin_phase();
        repeat_step(12, 1'b1, 4'b1100);
        check_eq("fault_latency", fault_at, DEB + 3);
        repeat_step(12, 1'b1, 4'b0000);
        check_eq("fault_sticky", sensor_fault, 1);
        check_eq("fault_sense_pass", {sense_up, sense_down}, 0);
        repeat_step(1, 1'b0, 4'b0000);
        check_eq("fault_cleared", sensor_fault, 0);

        // Reset while a press is being qualified
        repeat_step(4, 1'b1, 4'b0001);
        repeat_step(2, 1'b0, 4'b0001);
        check_eq("midreset_outputs", {key_up_pulse, key_down_pulse, keys_both, sense_up,
                                      sense_down, sensor_fault, key_stuck}, 0);
        begin_phase();
        repeat_step(20, 1'b1, 4'b0001);
        check_eq("midreset_count", up_pulses, 1);
        check_eq("midreset_latency", up_at, DEB + 3);
        repeat_step(10, 1'b1, 4'b0000);

        // Long hold, key_down pressed while key_up is held
        begin_phase();
        repeat_step(30, 1'b1, 4'b0001);
`ifdef KEY_STUCK_DETECT_EN
        check_eq("stuck_set", key_stuck, 1);
`else
        check_eq("stuck_absent", key_stuck, 0);
`endif
        repeat_step(10, 1'b1, 4'b0011);
        check_eq("held_no_down", dn_pulses, 0);
        repeat_step(12, 1'b1, 4'b0000);
        check_eq("stuck_released", key_stuck, 0);

        // Random segments with occasional reset
        for (int c = 0; c < 4; c++) hold[c] = 0;
        r = '0;
        for (int n = 0; n < 500; n++) begin
            for (int c = 0; c < 4; c++) begin
                if (hold[c] == 0) begin
                    r[c]    = 1'($urandom_range(0, 1));
                    hold[c] = $urandom_range(1, 9);
                end
                hold[c]--;
            end
            step($urandom_range(0, 149) != 0, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/door_input_cond.md
Name: door_input_cond

Overview:
Input conditioning stage directly upstream of the roll-door controller FSM. It synchronises, debounces and edge-detects the two push-buttons and two end-position sensors. It emits clean single-cycle key press pulses, debounced sensor levels and conflict/fault flags to the controller. All logic runs in the 2 MHz clk domain.

Parameters:
DEBOUNCE_CYCLES, 20000, consecutive cycles a changed input must persist before it is accepted (10 ms at 2 MHz); legal range 2..2^CNT_W-1
CNT_W, 15, debounce counter width
STUCK_CYCLES, 2000000, hold time (1 s) after which a key is flagged stuck (optional feature only)
STUCK_W, 21, stuck counter width

Ports:
clk  in  1  clock, posedge active
rst_n  in  1  reset, synchronous, active-low
key_up_raw  in  1  asynchronous open button, 1 = pressed
key_down_raw  in  1  asynchronous close button, 1 = pressed
sense_up_raw  in  1  asynchronous upper end sensor, 1 = door open
sense_down_raw  in  1  asynchronous lower end sensor, 1 = door closed
key_up_pulse  out  1  one-cycle pulse per accepted open press
key_down_pulse  out  1  one-cycle pulse per accepted close press
keys_both  out  1  level: both debounced keys held
sense_up  out  1  debounced upper sensor level
sense_down  out  1  debounced lower sensor level
sensor_fault  out  1  sticky: both debounced sensors were seen active together
key_stuck  out  1  level: a key is held beyond STUCK_CYCLES (0 when feature is compiled out)

Behaviour:
- Reset: the synchronous, active-low rst_n on clk clears all registers to 0 (synchroniser flops, debounce state, counters, stable levels, pulses, flags). All outputs read 0 during reset and on the first edge after release.
- Synchroniser: two flops per raw input; s2 is the synchronised value.
- Per-channel debounce FSM (4 identical instances), states STABLE and CHANGING; registers stable (reset 0), cnt[CNT_W-1:0] (reset 0).
  - STABLE: if s2 != stable, go to CHANGING with cnt <= 1; else hold cnt = 0.
  - CHANGING: if s2 == stable (bounce), go to STABLE with cnt <= 0.
  - CHANGING, s2 != stable, cnt == DEBOUNCE_CYCLES-1: stable <= s2, cnt <= 0, go to STABLE.
  - CHANGING otherwise: cnt <= cnt+1.
- Latency: a raw change held steady is reflected in stable DEBOUNCE_CYCLES+2 edges after the first edge that samples it.
- A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable. Any bounce restarts the count from zero.
- Key pulses, registered:
  - key_up_pulse = 1 for exactly one cycle, on the cycle after stable_up rises 0->1, provided stable_down == 0 at the rise.
  - key_down_pulse is symmetric.
  - If both stable keys rise on the same edge, or one rises while the other is held, no pulse is emitted.
  - A pulse never recurs while the key stays held.
  - Release (1->0) emits nothing.
- keys_both = stable_up & stable_down, registered (1 cycle after the stable values). The controller treats it as a stop request.
- sense_up / sense_down are the stable levels, driven directly.
- sensor_fault:
  - Set on the edge after stable sense_up & sense_down are both 1.
  - Stays 1 until rst_n; sensors continue to pass through unchanged.
- Reset mid-debounce abandons the count. A key still physically held after reset release is accepted as a new press: one pulse, DEBOUNCE_CYCLES+3 edges after release.
- Pulse outputs are mutually exclusive in every cycle.

Optional Feature:
Macro KEY_STUCK_DETECT_EN.
- Defined:
  - One STUCK_W counter per key, reset 0.
  - It increments while that key's stable level is 1, saturates at STUCK_CYCLES, and clears when stable is 0.
  - key_stuck = 1 while either counter is saturated.
  - While key_stuck = 1, both pulse outputs are forced to 0.
  - key_stuck clears on the edge after the stuck key's stable level falls.
- Not defined: no stuck counters are synthesised and key_stuck is tied to 0.

Test Plan:
(bench overrides DEBOUNCE_CYCLES=4, STUCK_CYCLES=16)
1. Clean press: key_up_raw 0->1 held 20 cycles -> exactly one key_up_pulse, 7 edges after first sampling edge; key_down_pulse stays 0.
2. Bounce: key_down_raw toggles 1,0,1,0 with 2-cycle widths, then held high -> no pulse during toggling; one key_down_pulse 7 edges after final steady high.
3. Simultaneous keys: both raws rise on the same edge -> no pulses, keys_both = 1 after 7 edges; release key_down -> keys_both 0, no key_up_pulse.
4. Sensor conflict: sense_up_raw = 1 then sense_down_raw = 1 -> sensor_fault rises 1 cycle after both debounced; deassert both sensors -> sensor_fault stays 1 until rst_n pulse.
5. Reset mid-operation: assert rst_n = 0 at cnt = 2 while key held -> all outputs 0; after release with key still held -> single key_up_pulse 7 edges later.
6. KEY_STUCK_DETECT_EN: hold key_up 30 cycles -> key_stuck = 1 after 16 debounced-high cycles; press key_down meanwhile -> no pulse; release key_up -> key_stuck 0. Without macro -> key_stuck constant 0.
